qea_state_unloader: RTL and testbench

- Readout engine on the far side of the QEA state-RAM port. It replaces the bench-driven readback sweep with synthesizable logic.
- On a start pulse, issued after QEA raises o_complete, it sweeps every state row and captures the PE_NUM packed amplitudes per row.
- It serializes the captured amplitudes as a valid/ready stream of one 64-bit complex amplitude per beat, towards a host DMA/UART bridge.
- It is the read-side counterpart of the state loader: it drives QEA i_state_ena/i_state_wea/i_state_addra and consumes QEA o_state_dout.

---
 rtl/qea_state_unloader_pkg.sv | 33 +++
 rtl/qea_row_serializer.sv | 47 ++++
 rtl/qea_state_unloader.sv | 95 +++++++++
 tb/tb_qea_state_unloader.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/qea_state_unloader_pkg.sv
// Shared constants, FSM encoding and row-count helper for the QEA state unloader.
package qea_state_unloader_pkg;

    localparam int PE_NUM_WIDTH     = 2;
    localparam int PE_NUM           = 1 << PE_NUM_WIDTH;
    localparam int DATA_WIDTH       = 32;
    localparam int STATE_DATA_WIDTH = DATA_WIDTH * 2;
    localparam int STATE_ADDR_WIDTH = 16;
    localparam int MAX_QBIT_WIDTH   = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_EMIT,
        ST_DONE
    } state_e;

    typedef logic [PE_NUM-1:0][STATE_DATA_WIDTH-1:0] row_t;
    // One bit wider than the address so 2^STATE_ADDR_WIDTH rows is representable.
    typedef logic [STATE_ADDR_WIDTH:0] row_cnt_t;

    function automatic row_cnt_t row_count(input logic [MAX_QBIT_WIDTH-1:0] qbit_num);
        logic [MAX_QBIT_WIDTH-1:0] sh;
        sh = qbit_num - MAX_QBIT_WIDTH'(PE_NUM_WIDTH);
        if (qbit_num <= MAX_QBIT_WIDTH'(PE_NUM_WIDTH))
            return row_cnt_t'(1);
        if (sh > MAX_QBIT_WIDTH'(STATE_ADDR_WIDTH))
            return row_cnt_t'(1) << STATE_ADDR_WIDTH;
        return row_cnt_t'(1) << sh;
    endfunction

endpackage

// File: rtl/qea_row_serializer.sv
// Captures one state row and streams its amplitudes lane by lane (lane 0 = MSB slice).
module qea_row_serializer
    import qea_state_unloader_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_cap,
    input  row_t                        i_cap_data,
    input  logic                        i_ready,
    output logic                        o_valid,
    output logic [STATE_DATA_WIDTH-1:0] o_data,
    output logic [PE_NUM_WIDTH-1:0]     o_lane,
    output logic                        o_row_done
);

    row_t                    row_buf;
    logic [PE_NUM_WIDTH-1:0] lane;
    logic                    valid;
    logic                    last_lane;
    logic                    fire;

    assign last_lane = (lane == PE_NUM_WIDTH'(PE_NUM - 1));
    assign fire      = valid && i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_buf <= '0;
            lane    <= '0;
            valid   <= 1'b0;
        end else if (i_cap) begin
            row_buf <= i_cap_data;
            lane    <= '0;
            valid   <= 1'b1;
        end else if (fire) begin
            if (last_lane)
                valid <= 1'b0;
            else
                lane <= lane + 1'b1;
        end
    end

    assign o_valid    = valid;
    assign o_data     = row_buf[PE_NUM_WIDTH'(PE_NUM - 1) - lane];
    assign o_lane     = lane;
    assign o_row_done = fire && last_lane;

endmodule

// File: rtl/qea_state_unloader.sv
// Sweeps the QEA state RAM row by row and streams every complex amplitude to the host.
module qea_state_unloader
    import qea_state_unloader_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               i_start,
    input  logic [MAX_QBIT_WIDTH-1:0]          i_qbit_num,
    output logic [PE_NUM-1:0]                  o_state_ena,
    output logic [PE_NUM-1:0]                  o_state_wea,
    output logic [STATE_ADDR_WIDTH-1:0]        o_state_addra,
    input  logic [PE_NUM*STATE_DATA_WIDTH-1:0] i_state_dout,
    output logic                               o_valid,
    input  logic                               i_ready,
    output logic [STATE_DATA_WIDTH-1:0]        o_data,
    output logic [STATE_ADDR_WIDTH-1:0]        o_row,
    output logic [PE_NUM_WIDTH-1:0]            o_lane,
    output logic                               o_last,
    output logic                               o_busy,
    output logic                               o_done
);

    state_e                  state, state_nxt;
    row_cnt_t                row, last_row;
    logic [RD_LATENCY-1:0]   vld_pipe;
    logic                    issue, capture, row_done, ser_valid;
    logic [PE_NUM_WIDTH-1:0] lane;
    row_t                    dout_row;

    assign issue    = (state == ST_ISSUE);
    // Read data is valid exactly RD_LATENCY cycles after the ISSUE cycle.
    assign capture  = vld_pipe[RD_LATENCY-1];
    assign dout_row = i_state_dout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row      <= '0;
            last_row <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe <= RD_LATENCY'({vld_pipe, issue});
            if (state == ST_IDLE && i_start) begin
                row      <= '0;
                last_row <= row_count(i_qbit_num) - 1'b1;
            end else if (state == ST_EMIT && row_done && row != last_row) begin
                row <= row + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (i_start) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (capture) state_nxt = ST_EMIT;
            ST_EMIT:  if (row_done) state_nxt = (row == last_row) ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    qea_row_serializer u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_cap      (capture),
        .i_cap_data (dout_row),
        .i_ready    (i_ready),
        .o_valid    (ser_valid),
        .o_data     (o_data),
        .o_lane     (lane),
        .o_row_done (row_done)
    );

    // Address follows the row counter, so it naturally holds between ISSUE cycles.
    assign o_state_ena   = {PE_NUM{issue}};
    assign o_state_wea   = '0;
    assign o_state_addra = row[STATE_ADDR_WIDTH-1:0];
    assign o_valid       = ser_valid;
    assign o_row         = row[STATE_ADDR_WIDTH-1:0];
    assign o_lane        = lane;
    assign o_last        = ser_valid && (lane == PE_NUM_WIDTH'(PE_NUM - 1)) && (row == last_row);
    assign o_busy        = (state != ST_IDLE) && (state != ST_DONE);
    assign o_done        = (state == ST_DONE);

endmodule

// File: tb/tb_qea_state_unloader.sv
// Directed scoreboard bench for qea_state_unloader (RD_LATENCY 1 and 3 instances).
module tb_qea_state_unloader;
    import qea_state_unloader_pkg::*;

    localparam int W  = STATE_DATA_WIDTH;
    localparam int AW = STATE_ADDR_WIDTH;
    localparam logic [W-1:0] POISON = 64'hDEAD_BEEF_DEAD_BEEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                      start, ready, valid, last, busy, done;
    logic [MAX_QBIT_WIDTH-1:0] qbit;
    logic [PE_NUM-1:0]         ena, wea;
    logic [AW-1:0]             addra, row;
    logic [PE_NUM*W-1:0]       dout;
    logic [W-1:0]              data;
    logic [PE_NUM_WIDTH-1:0]   lane;

    logic                      start3, valid3, last3, busy3, done3;
    logic                      ready3 = 1'b1;
    logic [PE_NUM-1:0]         ena3, wea3;
    logic [AW-1:0]             addra3, row3;
    logic [PE_NUM*W-1:0]       dout3;
    logic [W-1:0]              data3;
    logic [PE_NUM_WIDTH-1:0]   lane3;

    int n_cmp = 0;
    int n_mis = 0;
    int mode = 0;

    typedef struct packed {
        logic [W-1:0]            data;
        logic [AW-1:0]           row;
        logic [PE_NUM_WIDTH-1:0] lane;
        logic                    last;
    } beat_t;

    beat_t sb[$];

    qea_state_unloader #(.RD_LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(start), .i_qbit_num(qbit),
        .o_state_ena(ena), .o_state_wea(wea), .o_state_addra(addra), .i_state_dout(dout),
        .o_valid(valid), .i_ready(ready), .o_data(data), .o_row(row), .o_lane(lane),
        .o_last(last), .o_busy(busy), .o_done(done)
    );

    qea_state_unloader #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .i_start(start3), .i_qbit_num(qbit),
        .o_state_ena(ena3), .o_state_wea(wea3), .o_state_addra(addra3), .i_state_dout(dout3),
        .o_valid(valid3), .i_ready(ready3), .o_data(data3), .o_row(row3), .o_lane(lane3),
        .o_last(last3), .o_busy(busy3), .o_done(done3)
    );

    // Amplitude contents: mode 0 = {C0DE,row,0BEE,lane}; mode 1 = single 0.5 at row 0 lane 0.
    function automatic logic [W-1:0] amp(input int r, input int k, input int m);
        if (m == 1)
            return (r == 0 && k == 0) ? 64'h4000_0000_0000_0000 : 64'h0;
        return {16'hC0DE, r[15:0], 16'h0BEE, k[15:0]};
    endfunction

    function automatic logic [PE_NUM*W-1:0] row_data(input logic [AW-1:0] a, input int m);
        logic [PE_NUM*W-1:0] d;
        d = '0;
        for (int k = 0; k < PE_NUM; k++)
            d[(PE_NUM-k)*W-1 -: W] = amp(int'(a), k, m);
        return d;
    endfunction

    // State RAM models: data valid RD_LATENCY cycles after an enabled read, poison otherwise.
    logic [2:0]         ep1 = '0, ep3 = '0;
    logic [2:0][AW-1:0] ap1 = '0, ap3 = '0;
    always @(posedge clk) begin
        ep1 <= {ep1[1:0], &ena};
        ap1 <= {ap1[1:0], addra};
        ep3 <= {ep3[1:0], &ena3};
        ap3 <= {ap3[1:0], addra3};
    end
    assign dout  = ep1[0] ? row_data(ap1[0], mode) : {PE_NUM{POISON}};
    assign dout3 = ep3[2] ? row_data(ap3[2], mode) : {PE_NUM{POISON}};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_sweep(input int q);
        int    rows;
        beat_t b;
        rows = (q <= PE_NUM_WIDTH) ? 1 : (1 << (q - PE_NUM_WIDTH));
        for (int r = 0; r < rows; r++)
            for (int k = 0; k < PE_NUM; k++) begin
                b.data = amp(r, k, mode);
                b.row  = AW'(r);
                b.lane = PE_NUM_WIDTH'(k);
                b.last = (r == rows - 1) && (k == PE_NUM - 1);
                sb.push_back(b);
            end
    endtask

    // Runs one sweep on the RD_LATENCY=1 instance; called and returns on a negedge.
    task automatic run_sweep(input int q, input int ready_pct, input int ign_at,
                             input int abort_at, input int budget);
        int    popped, cyc, early_done, port_bad;
        beat_t cur, prev;
        bit    stall;
        popped = 0; cyc = 0; early_done = 0; port_bad = 0; stall = 0;
        prev = '0;
        push_sweep(q);
        qbit  = MAX_QBIT_WIDTH'(q);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (sb.size() > 0 && cyc < budget) begin
            start    = 1'b0;
            cur.data = data; cur.row = row; cur.lane = lane; cur.last = last;
            if (stall)
                chk("stall_hold", {valid, cur}, {1'b1, prev});
            if (wea !== '0 || (ena !== '0 && ena !== '1))
                port_bad++;
            if (valid && popped == abort_at) begin
                chk("abort_pos", {row, lane}, {16'd3, 2'd2});
                #2 rst_n = 1'b0;
                #1 chk("rst_async", {valid, busy, ena}, '0);
                ready = 1'b0;
                repeat (2) begin
                    @(negedge clk);
                    chk("rst_no_done", {done, valid, busy}, '0);
                end
                rst_n = 1'b1;
                sb.delete();
                @(negedge clk);
                return;
            end
            if (valid && popped == ign_at) begin
                start = 1'b1;
                qbit  = 6'd15;
                ign_at = -1;
            end
            ready = ($urandom_range(99) < ready_pct);
            if (valid && ready) begin
                popped++;
                chk("beat", cur, sb.pop_front());
            end
            stall = valid && !ready;
            prev  = cur;
            @(negedge clk);
            cyc++;
            if (done && sb.size() > 0)
                early_done++;
        end
        start = 1'b0;
        chk("timeout", sb.size(), 0);
        chk("no_early_done", early_done, 0);
        chk("port_drive", port_bad, 0);
        chk("done_pulse", {done, busy, valid}, 3'b100);
        @(negedge clk);
        chk("done_clear", {done, busy, valid}, '0);
    endtask

    initial begin
        int    cyc, first_valid;
        int    issue_cyc[$];
        beat_t cur;
        start = 0; start3 = 0; ready = 0; qbit = '0;
        repeat (2) @(negedge clk);
        chk("reset_outs", {ena, wea, addra, valid, data, row, lane, last, busy, done}, '0);
        chk("reset_outs3", {ena3, valid3, busy3, done3, last3}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rc_clamp", row_count(6'd22), 17'h10000);
        chk("rc_q15", row_count(6'd15), 17'd8192);
        chk("rc_q1", row_count(6'd1), 17'd1);

        mode = 0;
        run_sweep(2, 100, -1, -1, 100);
        run_sweep(0, 100, -1, -1, 100);
        run_sweep(5, 60, -1, -1, 2000);
        run_sweep(5, 100, 9, -1, 500);
        run_sweep(3, 100, -1, -1, 200);
        run_sweep(5, 70, -1, 14, 500);
        run_sweep(5, 100, -1, -1, 500);

        // RD_LATENCY=3 instance, ready always high.
        push_sweep(5);
        qbit = 6'd5; start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        cyc = 0; first_valid = -1;
        while (sb.size() > 0 && cyc < 300) begin
            if (ena3 === '1)
                issue_cyc.push_back(cyc);
            if (valid3) begin
                if (first_valid < 0) first_valid = cyc;
                cur.data = data3; cur.row = row3; cur.lane = lane3; cur.last = last3;
                chk("beat3", cur, sb.pop_front());
            end
            @(negedge clk);
            cyc++;
        end
        chk("timeout3", sb.size(), 0);
        chk("issue_cnt3", issue_cyc.size(), 8);
        if (issue_cyc.size() >= 2) begin
            chk("lat3", first_valid - issue_cyc[0], 4);
            chk("period3", issue_cyc[1] - issue_cyc[0], 8);
        end
        chk("done3", {done3, busy3}, 2'b10);
        @(negedge clk);

        mode = 1;
        run_sweep(15, 100, -1, -1, 60000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
